// File: rtl/egress_meta_tx.sv
// egress_meta_tx
//   Egress-side producer of per-packet metadata records. Parses the 32-bit
//   packet word stream (header word followed by L payload words), builds one
//   32-bit record per packet and queues it in a DEPTH-entry FIFO whose head is
//   presented on meta_out and popped by a one-cycle meta_out_ack pulse.
//
//   Optional feature, macro META_TIMESTAMP_EN: when defined, record bits [17:0]
//   carry an 18-bit free-running cycle count captured on the header cycle
//   instead of the header sequence number.
//
// Parameters
//   DEPTH    metadata FIFO entries (power of two, 2..64)
//   TIMEOUT  consecutive idle cycles inside a packet before it is aborted
//
// Ports
//   clk           in   system clock
//   reset         in   synchronous active-low reset
//   pkt_in_en     in   pkt_in holds a valid word this cycle
//   pkt_in        in   packet word [31:0]
//   meta_out_ack  in   pop FIFO head (one-cycle pulse)
//   meta_out      out  FIFO head record, bit 31 = valid, 0 when empty
//   meta_count    out  FIFO occupancy 0..DEPTH
//   drop_cnt      out  records lost to a full FIFO, saturating
//
// Header word: [31:30] src, [29:28] dst, [27:20] length L, [19:0] seq
// Record:      [31] valid, [30] err, [29:28] src, [27:26] dst,
//              [25:18] payload words received, [17:0] seq / timestamp
module egress_meta_tx #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pkt_in_en,
   input  logic [31:0] pkt_in,
   input  logic        meta_out_ack,
   output logic [31:0] meta_out,
   output logic [6:0]  meta_count,
   output logic [15:0] drop_cnt
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_PAYLOAD = 1'b1
   } state_t;

   state_t        r_state;
   logic [1:0]    r_src;
   logic [1:0]    r_dst;
   logic [7:0]    r_len;
   logic [17:0]   r_tag;
   logic [7:0]    r_wcnt;
   logic [9:0]    r_gap;

   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [6:0]    r_count;
   logic [31:0]   r_head;
   logic [15:0]   r_drop;

   logic [17:0]   w_tag;
   logic          w_push;
   logic [31:0]   w_rec;
   logic          w_pop;
   logic          w_full;
   logic          w_acc;
   logic          w_drop;
   logic [6:0]    w_count_nxt;
   logic [6:0]    w_count_after_pop;
   logic [AW-1:0] w_rptr_nxt;
   logic [31:0]   w_head_nxt;
   logic          w_unused;

   // Header bits [19:18] never reach the record; in the timestamp build
   // the whole sequence field is ignored.
   assign w_unused = ^pkt_in[19:0];

`ifdef META_TIMESTAMP_EN
   logic [17:0] r_ts;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ts <= '0;
      end else begin
         r_ts <= r_ts + 18'd1;
      end
   end

   assign w_tag = r_ts;
`else
   assign w_tag = pkt_in[17:0];
`endif

   // Record to push this cycle, if any. A zero-length header is an error
   // record built straight from the incoming word since nothing is latched yet.
   always_comb begin
      w_push = 1'b0;
      w_rec  = '0;
      case (r_state)
         S_IDLE: begin
            if (pkt_in_en && (pkt_in[27:20] == 8'd0)) begin
               w_push = 1'b1;
               w_rec  = {1'b1, 1'b1, pkt_in[31:30], pkt_in[29:28], 8'd0, w_tag};
            end
         end
         S_PAYLOAD: begin
            if (pkt_in_en) begin
               if ((r_wcnt + 8'd1) == r_len) begin
                  w_push = 1'b1;
                  w_rec  = {1'b1, 1'b0, r_src, r_dst, r_len, r_tag};
               end
            end else if ((r_gap + 10'd1) == 10'(TIMEOUT)) begin
               w_push = 1'b1;
               w_rec  = {1'b1, 1'b1, r_src, r_dst, r_wcnt, r_tag};
            end
         end
         default: begin
            w_push = 1'b0;
         end
      endcase
   end

   // Packet parser
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_wcnt  <= '0;
         r_gap   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (pkt_in_en) begin
                  r_src  <= pkt_in[31:30];
                  r_dst  <= pkt_in[29:28];
                  r_len  <= pkt_in[27:20];
                  r_tag  <= w_tag;
                  r_wcnt <= '0;
                  r_gap  <= '0;
                  if (pkt_in[27:20] != 8'd0) begin
                     r_state <= S_PAYLOAD;
                  end
               end
            end
            S_PAYLOAD: begin
               if (pkt_in_en) begin
                  r_wcnt <= r_wcnt + 8'd1;
                  r_gap  <= '0;
                  if ((r_wcnt + 8'd1) == r_len) begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_gap <= r_gap + 10'd1;
                  if ((r_gap + 10'd1) == 10'(TIMEOUT)) begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // FIFO control. A full FIFO still accepts a push when the same cycle pops.
   assign w_pop  = meta_out_ack && (r_count != 7'd0);
   assign w_full = (r_count == 7'(DEPTH));
   assign w_acc  = w_push && (!w_full || w_pop);
   assign w_drop = w_push && !w_acc;

   assign w_count_after_pop = w_pop ? (r_count - 7'd1) : r_count;
   assign w_count_nxt       = w_acc ? (w_count_after_pop + 7'd1) : w_count_after_pop;
   assign w_rptr_nxt        = w_pop ? (r_rptr + AW'(1)) : r_rptr;

   // meta_out is registered, so the next head is resolved here: when the
   // FIFO would be empty after the pop, the record being pushed becomes the
   // head directly (it is not yet readable from r_mem).
   always_comb begin
      if (w_count_nxt == 7'd0) begin
         w_head_nxt = '0;
      end else if (w_acc && (w_count_after_pop == 7'd0)) begin
         w_head_nxt = w_rec;
      end else begin
         w_head_nxt = r_mem[w_rptr_nxt];
      end
   end

   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_mem[r_wptr] <= w_rec;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_head  <= '0;
         r_drop  <= '0;
      end else begin
         if (w_acc) begin
            r_wptr <= r_wptr + AW'(1);
         end
         r_rptr  <= w_rptr_nxt;
         r_count <= w_count_nxt;
         r_head  <= w_head_nxt;
         if (w_drop && (r_drop != 16'hFFFF)) begin
            r_drop <= r_drop + 16'd1;
         end
      end
   end

   assign meta_out   = r_head;
   assign meta_count = r_count;
   assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_egress_meta_tx.sv
// Scoreboard bench for egress_meta_tx (DEPTH=8, TIMEOUT=4). Stimulus tasks
// drive one cycle at a time and announce any record the DUT must push that
// cycle; a reference FIFO applies pushes/pops at the clock edge and a monitor
// compares the presented head, occupancy and drop count on every falling edge.
module tb_egress_meta_tx;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        pkt_in_en;
   logic [31:0] pkt_in;
   logic        meta_out_ack;
   logic [31:0] meta_out;
   logic [6:0]  meta_count;
   logic [15:0] drop_cnt;

   always #5 clk = ~clk;

   egress_meta_tx #(
      .DEPTH  (DEPTH),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pkt_in_en   (pkt_in_en),
      .pkt_in      (pkt_in),
      .meta_out_ack(meta_out_ack),
      .meta_out    (meta_out),
      .meta_count  (meta_count),
      .drop_cnt    (drop_cnt)
   );

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];
   int          exp_drop = 0;
   logic        sb_push = 1'b0;
   logic [31:0] sb_rec = '0;
   logic [17:0] tb_cyc = '0;
   logic [17:0] hdr_ts = '0;
   logic        mon_en = 1'b0;
   logic [31:0] mon_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
      end
   endtask

   // Cycles since reset, as seen by the timestamp build.
   always @(posedge clk) begin
      if (!reset) tb_cyc <= '0;
      else        tb_cyc <= tb_cyc + 18'd1;
   end

   // Reference FIFO: pop first, then push if there is room.
   always @(posedge clk) begin
      if (!reset) begin
         exp_q.delete();
         exp_drop = 0;
         mon_en   = 1'b1;
      end else begin
         if (meta_out_ack && (exp_q.size() > 0)) void'(exp_q.pop_front());
         if (sb_push) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(sb_rec);
            else if (exp_drop < 65535) exp_drop++;
         end
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (mon_en) begin
         mon_exp = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
         check("meta_out", meta_out, mon_exp);
         check("meta_count", 32'(meta_count), 32'(exp_q.size()));
         check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
      end
   end

   // One cycle of stimulus. 'push'/'rec' is the record the DUT must push on
   // the coming edge; 'hdr' marks a header word (timestamp capture cycle).
   task automatic drive(input logic rstn, input logic en, input logic [31:0] w,
                        input logic ack, input logic push, input logic [31:0] rec,
                        input logic hdr);
      @(posedge clk);
      #1;
      reset        = rstn;
      pkt_in_en    = en;
      pkt_in       = w;
      meta_out_ack = ack;
      if (hdr) hdr_ts = tb_cyc;
      sb_push = push;
`ifdef META_TIMESTAMP_EN
      sb_rec = {rec[31:18], hdr_ts};
`else
      sb_rec = rec;
`endif
   endtask

   task automatic idle(input logic ack);
      drive(1'b1, 1'b0, 32'h0, ack, 1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      reset        = 1'b0;
      pkt_in_en    = 1'b0;
      pkt_in       = '0;
      meta_out_ack = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

      // Basic packet: src1 dst1 L=3 seq 7 -> {v=1,err=0,01,01,len3,seq7}
      drive(1'b1, 1'b1, 32'h5030_0007, 1'b0, 1'b0, 32'h0, 1'b1);
      drive(1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b1, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b1, 1'b1, 32'h3333_3333, 1'b0, 1'b1, 32'h940C_0007, 1'b0);
      idle(1'b0);
      idle(1'b1);     // pop
      idle(1'b1);     // ack while empty
      idle(1'b0);

      // Zero length, then the next word is itself a header
      drive(1'b1, 1'b1, 32'hC000_0005, 1'b0, 1'b1, 32'hF000_0005, 1'b1);
      drive(1'b1, 1'b1, 32'h4000_0011, 1'b0, 1'b1, 32'hD000_0011, 1'b1);
      idle(1'b0);
      idle(1'b1);
      idle(1'b1);
      idle(1'b0);

      // Timeout: src0 dst2 L=5 seq 9, 2 words, abort on 4th idle cycle
      drive(1'b1, 1'b1, 32'h2050_0009, 1'b0, 1'b0, 32'h0, 1'b1);
      drive(1'b1, 1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b1, 1'b1, 32'hAAAA_0002, 1'b0, 1'b0, 32'h0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      idle(1'b0);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC808_0009, 1'b0);
      drive(1'b1, 1'b1, 32'hC000_0005, 1'b0, 1'b1, 32'hF000_0005, 1'b1);
      idle(1'b0);
      idle(1'b1);
      idle(1'b1);
      idle(1'b0);

      // Full FIFO: ten one-word packets, no ack -> 8 held, 2 dropped
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, 32'h0010_0000 | 32'(i), 1'b0, 1'b0, 32'h0, 1'b1);
         drive(1'b1, 1'b1, 32'hABCD_0000, 1'b0, 1'b1, 32'h8004_0000 | 32'(i), 1'b0);
      end
      idle(1'b0);
      // Completing packet with a simultaneous ack: pop-then-push
      drive(1'b1, 1'b1, 32'h0010_00AA, 1'b0, 1'b0, 32'h0, 1'b1);
      drive(1'b1, 1'b1, 32'hABCD_0001, 1'b1, 1'b1, 32'h8004_00AA, 1'b0);
      idle(1'b0);
      for (int i = 0; i < 9; i++) idle(1'b1);
      idle(1'b0);

      // Reset mid-packet with a record still queued
      drive(1'b1, 1'b1, 32'hC000_0005, 1'b0, 1'b1, 32'hF000_0005, 1'b1);
      drive(1'b1, 1'b1, 32'h5030_0007, 1'b0, 1'b0, 32'h0, 1'b1);
      drive(1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b1, 1'b1, 32'h4000_0011, 1'b0, 1'b1, 32'hD000_0011, 1'b1);
      drive(1'b1, 1'b1, 32'h8000_0022, 1'b0, 1'b1, 32'hE000_0022, 1'b1);
      idle(1'b0);
      idle(1'b1);
      idle(1'b1);
      idle(1'b0);
      idle(1'b0);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
